// File: rtl/pico_job_sequencer_if.sv
// rtl/pico_job_sequencer_if.sv - request, core handshake and result signals of pico_job_sequencer
interface pico_job_sequencer_if;
  logic        req;
  logic        req_ready;
  logic        start_pico;
  logic        pico_done;
  logic [7:0]  pico_data;
  logic [7:0]  result_data;
  logic        result_valid;
  logic        result_ready;
  logic        timeout_err;
  logic [15:0] job_count;
  logic        busy;

  modport master (
    input  req,
    output req_ready,
    output start_pico,
    input  pico_done,
    input  pico_data,
    output result_data,
    output result_valid,
    input  result_ready,
    output timeout_err,
    output job_count,
    output busy
  );

  modport slave (
    output req,
    input  req_ready,
    input  start_pico,
    output pico_done,
    output pico_data,
    input  result_data,
    input  result_valid,
    output result_ready,
    input  timeout_err,
    input  job_count,
    input  busy
  );
endinterface

// File: rtl/pico_job_sequencer.sv
// rtl/pico_job_sequencer.sv - PicoBlaze job sequencer: four-phase start/done handshake,
// per-wait timeout and a result FIFO with a registered head.
module pico_job_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  pico_job_sequencer_if.master bus
);

  localparam int              PW       = $clog2(FIFO_DEPTH);
  localparam int              CW       = PW + 1;
  localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_WAIT_DONE    = 2'd1,
    S_WAIT_RELEASE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [15:0]   r_tmo_cnt;
  logic [15:0]   r_job_count;
  logic          r_timeout_err;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_result_data;

  logic          w_req_ready;
  logic          w_start_pico;
  logic          w_busy;
  logic          w_accept;
  logic          w_tmo_hit;
  logic          w_push;
  logic          w_pop;
  logic          w_abort;
  logic [PW-1:0] w_rd_ptr_inc;

  assign w_tmo_hit    = (r_tmo_cnt == TMO_LAST);
  assign w_accept     = bus.req && w_req_ready;
  assign w_push       = (r_state == S_WAIT_DONE) && bus.pico_done;
  assign w_pop        = (r_count != '0) && bus.result_ready;
  assign w_abort      = w_tmo_hit && (((r_state == S_WAIT_DONE) && !bus.pico_done) ||
                                      ((r_state == S_WAIT_RELEASE) && bus.pico_done));
  assign w_rd_ptr_inc = r_rd_ptr + PW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (bus.pico_done)  w_next_state = S_WAIT_RELEASE;
        else if (w_tmo_hit) w_next_state = S_IDLE;
      end
      S_WAIT_RELEASE: begin
        if (!bus.pico_done || w_tmo_hit) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // start_pico follows the state register, so an async reset drops it at once
  always_comb begin
    w_req_ready  = 1'b0;
    w_start_pico = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE:         w_req_ready = (r_count < DEPTH_C) && !bus.pico_done;
      S_WAIT_DONE: begin
        w_start_pico = 1'b1;
        w_busy       = 1'b1;
      end
      S_WAIT_RELEASE: w_busy = 1'b1;
      default:        w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt     <= '0;
      r_job_count   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_push) r_tmo_cnt <= '0;
      else                             r_tmo_cnt <= r_tmo_cnt + 16'd1;
      if (w_push) r_job_count <= r_job_count + 16'd1;
      r_timeout_err <= w_abort;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.pico_data;
  end

  // Head register: holds the last head when empty, bypasses the pushed byte when
  // the FIFO is (or is about to become) otherwise empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_result_data <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if (w_pop && (r_count > CW'(1)))
        r_result_data <= r_mem[w_rd_ptr_inc];
      else if (w_push && ((r_count == '0) || w_pop))
        r_result_data <= bus.pico_data;
    end
  end

  assign bus.req_ready    = w_req_ready;
  assign bus.start_pico   = w_start_pico;
  assign bus.busy         = w_busy;
  assign bus.result_data  = r_result_data;
  assign bus.result_valid = (r_count != '0);
  assign bus.timeout_err  = r_timeout_err;
  assign bus.job_count    = r_job_count;

endmodule

// File: tb/tb_pico_job_sequencer.sv
// tb/tb_pico_job_sequencer.sv - self-checking bench for pico_job_sequencer
module tb_pico_job_sequencer;
  localparam int T       = 16;
  localparam int DEPTH   = 4;
  localparam int K_NORM  = 0;
  localparam int K_HANG  = 1;
  localparam int K_STUCK = 2;

  logic clk = 1'b0;
  logic reset;
  pico_job_sequencer_if bus ();

  pico_job_sequencer #(.TIMEOUT_CYCLES(T), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          errors   = 0;
  logic [7:0]  q[$];
  logic [7:0]  last_head = 8'h00;
  logic [15:0] exp_jobs  = 16'd0;
  logic        exp_tmo   = 1'b0;
  int          start_hi  = 0;
  int          tmo_seen  = 0;
  int          rr_mode   = 0;
  logic        dut_acc   = 1'b0;
  logic        job_acc   = 1'b0;

  typedef struct {
    int          kind;
    int          lat;
    int          rel;
    logic [7:0]  data;
    int          rr;
    int          drain;
    logic        exp_acc;
    logic [15:0] exp_jobs;
    int          exp_start_hi;
    int          exp_tmo;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: entered just after a rising edge with inputs applied,
  // compares DUT outputs with the FIFO/count model, then advances the model.
  task automatic tick(input logic idle, input logic e_start, input logic abort,
                      input logic push, input logic [7:0] pdata, output logic acc);
    logic e_ready;
    logic pop;
    if (rr_mode == 2) bus.result_ready = 1'($urandom_range(0, 1));
    else              bus.result_ready = (rr_mode == 1);
    #1;
    e_ready = idle && (q.size() < DEPTH) && !bus.pico_done;
    chk("req_ready",    32'(bus.req_ready),    32'(e_ready));
    chk("start_pico",   32'(bus.start_pico),   32'(e_start));
    chk("busy",         32'(bus.busy),         32'(!idle));
    chk("timeout_err",  32'(bus.timeout_err),  32'(exp_tmo));
    chk("result_valid", 32'(bus.result_valid), 32'(q.size() != 0));
    if (q.size() != 0) last_head = q[0];
    chk("result_data",  32'(bus.result_data),  32'(last_head));
    chk("job_count",    32'(bus.job_count),    32'(exp_jobs));
    if (bus.start_pico)  start_hi++;
    if (bus.timeout_err) tmo_seen++;
    dut_acc = bus.req && bus.req_ready;
    acc     = idle && bus.req && e_ready;
    pop     = (q.size() != 0) && bus.result_ready;
    exp_tmo = abort;
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(pdata);
      exp_jobs++;
    end
  endtask

  task automatic run_job(input int kind, input int lat, input int rel,
                         input logic [7:0] data, output logic acc);
    logic a;
    bus.req = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, acc);
    job_acc = dut_acc;
    bus.req = 1'b0;
    if (!acc) return;
    if (kind == K_HANG) begin
      for (int i = 0; i < T; i++) tick(1'b0, 1'b1, (i == T - 1), 1'b0, 8'h00, a);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, a);
      return;
    end
    for (int i = 0; i < lat; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, a);
    bus.pico_done = 1'b1;
    bus.pico_data = data;
    tick(1'b0, 1'b1, 1'b0, 1'b1, data, a);
    bus.pico_data = 8'($urandom);
    if (kind == K_STUCK) begin
      for (int i = 0; i < T; i++) tick(1'b0, 1'b0, (i == T - 1), 1'b0, 8'h00, a);
      bus.req = 1'b1;
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, a);
      bus.req = 1'b0;
    end else begin
      for (int i = 0; i < rel; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, a);
    end
    bus.pico_done = 1'b0;
    tick((kind == K_STUCK), 1'b0, 1'b0, 1'b0, 8'h00, a);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    int   r;
    int   kind;
    int   gap;

    //        kind     lat rel data   rr drain acc   jobs    start_hi tmo
    vecs[0]  = '{K_NORM,  10, 3, 8'h5A, 0, 2, 1'b1, 16'd1,  11, 0};
    vecs[1]  = '{K_NORM,   2, 1, 8'h01, 0, 0, 1'b1, 16'd2,   3, 0};
    vecs[2]  = '{K_NORM,   0, 0, 8'h02, 0, 0, 1'b1, 16'd3,   1, 0};
    vecs[3]  = '{K_NORM,   3, 2, 8'h03, 0, 0, 1'b1, 16'd4,   4, 0};
    vecs[4]  = '{K_NORM,   1, 1, 8'h04, 0, 0, 1'b1, 16'd5,   2, 0};
    vecs[5]  = '{K_NORM,   1, 1, 8'h05, 0, 6, 1'b0, 16'd5,   0, 0};
    vecs[6]  = '{K_NORM,   0, 0, 8'hA1, 0, 0, 1'b1, 16'd6,   1, 0};
    vecs[7]  = '{K_NORM,   0, 0, 8'hA2, 0, 0, 1'b1, 16'd7,   1, 0};
    vecs[8]  = '{K_NORM,   0, 0, 8'hA3, 1, 4, 1'b1, 16'd8,   1, 0};
    vecs[9]  = '{K_HANG,   0, 0, 8'h00, 0, 0, 1'b1, 16'd8,  16, 1};
    vecs[10] = '{K_STUCK,  4, 0, 8'h77, 0, 3, 1'b1, 16'd9,   5, 1};

    reset            = 1'b1;
    bus.req          = 1'b0;
    bus.pico_done    = 1'b0;
    bus.pico_data    = 8'h00;
    bus.result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready",    32'(bus.req_ready),    32'd1);
    chk("rst_start_pico",   32'(bus.start_pico),   32'd0);
    chk("rst_busy",         32'(bus.busy),         32'd0);
    chk("rst_result_valid", 32'(bus.result_valid), 32'd0);
    chk("rst_result_data",  32'(bus.result_data),  32'h00);
    chk("rst_timeout_err",  32'(bus.timeout_err),  32'd0);
    chk("rst_job_count",    32'(bus.job_count),    32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      rr_mode  = vecs[i].rr;
      start_hi = 0;
      tmo_seen = 0;
      run_job(vecs[i].kind, vecs[i].lat, vecs[i].rel, vecs[i].data, a);
      chk("vec_accept",   32'(job_acc),       32'(vecs[i].exp_acc));
      chk("vec_jobs",     32'(bus.job_count), 32'(vecs[i].exp_jobs));
      chk("vec_start_hi", 32'(start_hi),      32'(vecs[i].exp_start_hi));
      chk("vec_timeouts", 32'(tmo_seen),      32'(vecs[i].exp_tmo));
      rr_mode = 1;
      for (int d = 0; d < vecs[i].drain; d++) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, a);
    end

    for (int j = 0; j < 80; j++) begin
      r       = int'($urandom_range(0, 9));
      kind    = (r < 8) ? K_NORM : ((r == 8) ? K_HANG : K_STUCK);
      rr_mode = ($urandom_range(0, 3) == 0) ? 0 : 2;
      gap     = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, a);
      run_job(kind, int'($urandom_range(0, T - 1)), int'($urandom_range(0, T - 1)),
              8'($urandom), a);
    end

    // Reset in WAIT_DONE with two results queued
    rr_mode = 1;
    for (int d = 0; d < 6; d++) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, a);
    rr_mode = 0;
    run_job(K_NORM, 1, 1, 8'hC1, a);
    run_job(K_NORM, 2, 0, 8'hC2, a);
    bus.req = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, a);
    bus.req = 1'b0;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, a);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, a);
    reset = 1'b1;
    #1;
    chk("mid_rst_start_pico",   32'(bus.start_pico),   32'd0);
    chk("mid_rst_busy",         32'(bus.busy),         32'd0);
    chk("mid_rst_result_valid", 32'(bus.result_valid), 32'd0);
    chk("mid_rst_result_data",  32'(bus.result_data),  32'h00);
    chk("mid_rst_job_count",    32'(bus.job_count),    32'd0);
    chk("mid_rst_timeout_err",  32'(bus.timeout_err),  32'd0);
    chk("mid_rst_req_ready",    32'(bus.req_ready),    32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    last_head = 8'h00;
    exp_jobs  = 16'd0;
    exp_tmo   = 1'b0;
    rr_mode   = 2;
    run_job(K_NORM, 3, 2, 8'h3C, a);
    chk("post_rst_jobs", 32'(bus.job_count), 32'd1);
    rr_mode = 1;
    for (int d = 0; d < 3; d++) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, a);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pico_job_sequencer.md
# pico_job_sequencer

Host-side controller for the PicoBlaze speech-synthesis core. It accepts processing requests from upstream logic and drives the core's `start_pico` input. It watches the core's `pico_done` output, captures the core's 8-bit `output_data` on completion and queues results in a small FIFO for the downstream audio path. A per-job timeout recovers from a hung or unprogrammed core.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: cycles allowed in each wait state before the job is aborted; legal range 2..65535.
- `FIFO_DEPTH`, default 4: result FIFO entries; must be a power of two, at least 2.

Ports:
- `clk`  in  1  system clock, the same clock as the PicoBlaze core.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  job request; accepted in any cycle where `req` and `req_ready` are both 1.
- `req_ready`  out  1  sequencer can accept a job.
- `start_pico`  out  1  drives the core's `start_pico` input.
- `pico_done`  in  1  from the core's `pico_done` output.
- `pico_data`  in  8  from the core's `output_data` output.
- `result_data`  out  8  FIFO head.
- `result_valid`  out  1  FIFO not empty.
- `result_ready`  in  1  downstream pops the head when `result_valid` and `result_ready` are both 1.
- `timeout_err`  out  1  one-cycle pulse when a job is aborted.
- `job_count`  out  16  number of successfully completed jobs; wraps at 16 bits.
- `busy`  out  1  state is not IDLE.

## Operation
- The handshake with the core is four-phase: raise `start_pico`, core raises `pico_done`, drop `start_pico`, core drops `pico_done`.
- Core software writes `output_data` (port 80h) before `pico_done` (port 40h). Therefore `pico_data` is valid in the first cycle `pico_done`=1 is observed.
- All core I/O is in the `clk` domain. No synchronizers are used.

FSM states:
- IDLE
  - `req_ready` = (FIFO count < `FIFO_DEPTH`) AND (`pico_done`=0).
  - On accept: go to WAIT_DONE and clear the timeout counter.
- WAIT_DONE
  - `start_pico`=1.
  - If `pico_done`=1: write `pico_data` into the FIFO, increment `job_count`, go to WAIT_RELEASE, clear the timeout counter.
  - Else if the counter reaches `TIMEOUT_CYCLES`-1: pulse `timeout_err`, go to IDLE, write nothing.
- WAIT_RELEASE
  - `start_pico`=0.
  - If `pico_done`=0: go to IDLE.
  - Else if the counter reaches `TIMEOUT_CYCLES`-1: pulse `timeout_err`, go to IDLE. The completed result stays in the FIFO.

Outputs by state:
- `busy`=1 in WAIT_DONE and WAIT_RELEASE.
- `req_ready`=0 outside IDLE.

FIFO:
- Circular buffer with log2(`FIFO_DEPTH`) bit pointers and a count 0..`FIFO_DEPTH`.
- Pointers wrap modulo `FIFO_DEPTH`.
- Space is guaranteed at accept time (only one job can be in flight), so a push never meets a full FIFO.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal at any count, including count=1.
- A pop while empty is ignored.

Boundary conditions:
- `req` while not ready is ignored; it is not queued.
- A stale `pico_done`=1 in IDLE blocks accept until it clears.
- `job_count` wraps from FFFFh to 0000h.

## Timing
- Reset values (asynchronous): state IDLE, `start_pico`=0, `result_valid`=0, `result_data`=00h, `timeout_err`=0, `job_count`=0, `busy`=0, FIFO empty with pointers 0.
- `req_ready` after reset is 1 if `pico_done`=0.
- Accept in cycle N: `start_pico`=1 and `busy`=1 from cycle N+1.
- `pico_done` first seen 1 in cycle M:
  - `start_pico`=0 from M+1.
  - The FIFO entry is visible from M+1; if the FIFO was empty, `result_valid`=1 and `result_data`=captured byte at M+1.
  - `job_count` increments at M+1.
- `pico_done` seen 0 in WAIT_RELEASE at cycle K: IDLE, and `req_ready` possible, at K+1. The minimum job turnaround is 3 cycles.
- Timeout: with no `pico_done` for `TIMEOUT_CYCLES` cycles of WAIT_DONE, `timeout_err`=1 for exactly one cycle and `start_pico`=0 in that same cycle.
- Reset asserted mid-job: `start_pico` drops immediately (asynchronously) and FIFO contents are discarded.
- Pop at cycle P: the next entry, if any, appears on `result_data` at P+1. `result_data` holds its value when the FIFO is empty.

## Test plan
- Basic job: `req` pulse, model core answers `pico_done`=1 with `pico_data`=5Ah after 10 cycles and drops it 3 cycles later -> `start_pico` high for exactly 11 cycles; `result_data`=5Ah with `result_valid` one cycle after done; `job_count`=1.
- FIFO fill with `FIFO_DEPTH`=4, `result_ready`=0: five back-to-back jobs returning 01h..05h -> `req_ready`=0 after the 4th result; the 5th `req` is ignored. Raising `result_ready` pops 01h, 02h, 03h, 04h in order, and `req_ready` returns to 1 after the first pop.
- Simultaneous push/pop at count=1 with `result_ready`=1 held -> count stays 1; output sequence is correct with no lost or duplicated bytes.
- Timeout with `TIMEOUT_CYCLES`=16: core never raises `pico_done` -> one-cycle `timeout_err`, `start_pico`=0 in the same cycle, no FIFO write, `job_count` unchanged, IDLE next.
- Stuck done: `pico_done` held 1 after completion -> `timeout_err` after 16 cycles; result retained; `req_ready` stays 0 until `pico_done` falls.
- Reset mid-WAIT_DONE with 2 entries queued -> all outputs return to reset values asynchronously; `result_valid`=0.
